// File: rtl/seq_gen.sv
// Serial pattern generator: shifts a captured pattern MSB-first for Rep+1 frames with GAP idle cycles between.
// Latency 1 from Start to first bit; Start is only honoured while Ready is high (no other backpressure).
module seq_gen #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [3:0]       len,
  input  logic [3:0]       rep,
  input  logic             abort,
  output logic             x,
  output logic             xvalid,
  output logic             ready,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAPW, DONE} state_t;

  localparam logic [3:0] WL = 4'(WIDTH);
  localparam logic [3:0] GL = 4'(GAP);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_data, sh_data_nxt;
  logic [3:0]       sh_len, sh_len_nxt;
  logic [3:0]       bitcnt, bitcnt_nxt;
  logic [3:0]       repcnt, repcnt_nxt;
  logic [3:0]       gapcnt, gapcnt_nxt;
  logic             x_nxt, xvalid_nxt, ready_nxt, done_nxt;
  logic [3:0]       len_clamp;

  assign len_clamp = (len == 4'd0 || len > WL) ? WL : len;

  function automatic logic bit_at(input logic [WIDTH-1:0] d, input logic [3:0] i);
    logic [WIDTH-1:0] s;
    s = d >> i;
    return s[0];
  endfunction

  always_comb begin
    state_nxt   = state;
    sh_data_nxt = sh_data;
    sh_len_nxt  = sh_len;
    bitcnt_nxt  = bitcnt;
    repcnt_nxt  = repcnt;
    gapcnt_nxt  = gapcnt;
    x_nxt       = 1'b0;
    xvalid_nxt  = 1'b0;
    ready_nxt   = 1'b0;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        if (start) begin
          sh_data_nxt = data;
          sh_len_nxt  = len_clamp;
          repcnt_nxt  = rep;
          bitcnt_nxt  = len_clamp - 4'd1;
          x_nxt       = bit_at(data, len_clamp - 4'd1);
          xvalid_nxt  = 1'b1;
          ready_nxt   = 1'b0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        // bitcnt holds the index of the bit currently on x
        if (bitcnt != 4'd0) begin
          bitcnt_nxt = bitcnt - 4'd1;
          x_nxt      = bit_at(sh_data, bitcnt - 4'd1);
          xvalid_nxt = 1'b1;
        end else if (repcnt != 4'd0) begin
          repcnt_nxt = repcnt - 4'd1;
          if (GAP > 0) begin
            state_nxt  = GAPW;
            gapcnt_nxt = GL - 4'd1;
          end else begin
            bitcnt_nxt = sh_len - 4'd1;
            x_nxt      = bit_at(sh_data, sh_len - 4'd1);
            xvalid_nxt = 1'b1;
          end
        end else begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end
      end
      GAPW: begin
        if (gapcnt != 4'd0) begin
          gapcnt_nxt = gapcnt - 4'd1;
        end else begin
          state_nxt  = SHIFT;
          bitcnt_nxt = sh_len - 4'd1;
          x_nxt      = bit_at(sh_data, sh_len - 4'd1);
          xvalid_nxt = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
      end
    endcase

    if (abort && state != IDLE) begin
      state_nxt  = IDLE;
      x_nxt      = 1'b0;
      xvalid_nxt = 1'b0;
      done_nxt   = 1'b0;
      ready_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      sh_data <= '0;
      sh_len  <= '0;
      bitcnt  <= '0;
      repcnt  <= '0;
      gapcnt  <= '0;
      x       <= 1'b0;
      xvalid  <= 1'b0;
      ready   <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      sh_data <= sh_data_nxt;
      sh_len  <= sh_len_nxt;
      bitcnt  <= bitcnt_nxt;
      repcnt  <= repcnt_nxt;
      gapcnt  <= gapcnt_nxt;
      x       <= x_nxt;
      xvalid  <= xvalid_nxt;
      ready   <= ready_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: one instance with GAP=1 and one with GAP=0 share the same stimulus.
// Per-cycle output code is {xvalid, x, done, ready}, sampled 1 time unit after each rising edge.
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       clr, start, abort;
  logic [7:0] data;
  logic [3:0] len, rep;
  logic       x, xvalid, ready, done;
  logic       x0, xvalid0, ready0, done0;

  int vectors    = 0;
  int miscompares = 0;

  logic [3:0] exp_q[$];
  logic [3:0] exp0_q[$];

  localparam logic [3:0] C_GAP  = 4'b0000;
  localparam logic [3:0] C_DONE = 4'b0010;
  localparam logic [3:0] C_IDLE = 4'b0001;

  always #5 clk = ~clk;

  seq_gen #(.WIDTH(8), .GAP(1)) dut (
    .clk(clk), .clr(clr), .start(start), .data(data), .len(len), .rep(rep), .abort(abort),
    .x(x), .xvalid(xvalid), .ready(ready), .done(done)
  );

  seq_gen #(.WIDTH(8), .GAP(0)) dut0 (
    .clk(clk), .clr(clr), .start(start), .data(data), .len(len), .rep(rep), .abort(abort),
    .x(x0), .xvalid(xvalid0), .ready(ready0), .done(done0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed {xv,x,done,rdy}=%b, expected %b", tag, obs, expv);
    end
  endtask

  task automatic chk_both(input string tag, input logic [3:0] expv);
    chk({tag, " dut"},  {xvalid, x, done, ready},     expv);
    chk({tag, " dut0"}, {xvalid0, x0, done0, ready0}, expv);
  endtask

  // which: 0 = GAP=1 queue, 1 = GAP=0 queue, 2 = both
  task automatic push_code(input logic [3:0] code, input int which);
    if (which != 1) exp_q.push_back(code);
    if (which != 0) exp0_q.push_back(code);
  endtask

  task automatic push_bits(input logic [15:0] bits, input int n, input int which);
    for (int i = n - 1; i >= 0; i--) push_code({1'b1, bits[i], 2'b00}, which);
  endtask

  // Entered in cycle 1 of a transfer; compares one queued code per cycle.
  task automatic run_check(input string tag);
    while (exp0_q.size() < exp_q.size()) exp0_q.push_back(C_IDLE);
    while (exp_q.size() < exp0_q.size()) exp_q.push_back(C_IDLE);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s dut c%0d", tag, i + 1),  {xvalid, x, done, ready},     exp_q[i]);
      chk($sformatf("%s dut0 c%0d", tag, i + 1), {xvalid0, x0, done0, ready0}, exp0_q[i]);
      step();
    end
    exp_q.delete();
    exp0_q.delete();
  endtask

  task automatic launch(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
    data  = d;
    len   = l;
    rep   = r;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; abort = 1'b0; data = '0; len = '0; rep = '0;
    step();
    step();
    chk_both("reset", C_IDLE);

    // clear outranks a simultaneous start
    start = 1'b1; data = 8'hB2; len = 4'd8;
    step();
    chk_both("clr_over_start", C_IDLE);
    clr = 1'b0; start = 1'b0;
    step();
    chk_both("idle_after_clr", C_IDLE);

    abort = 1'b1;
    step();
    chk_both("abort_in_idle", C_IDLE);
    abort = 1'b0;
    step();

    // full 8-bit frame
    push_bits(16'h00B2, 8, 2); push_code(C_DONE, 2); push_code(C_IDLE, 2);
    launch(8'hB2, 4'd8, 4'd0);
    run_check("b2_len8");

    push_bits(16'h0005, 3, 2); push_code(C_DONE, 2); push_code(C_IDLE, 2);
    launch(8'h05, 4'd3, 4'd0);
    run_check("05_len3");

    push_bits(16'h00B2, 8, 2); push_code(C_DONE, 2); push_code(C_IDLE, 2);
    launch(8'hB2, 4'd0, 4'd0);
    run_check("b2_len0");

    push_bits(16'h00B2, 8, 2); push_code(C_DONE, 2); push_code(C_IDLE, 2);
    launch(8'hB2, 4'd12, 4'd0);
    run_check("b2_len12");

    // two frames: gap of one cycle on dut, back-to-back on dut0
    push_bits(16'h000D, 4, 0); push_code(C_GAP, 0); push_bits(16'h000D, 4, 0);
    push_code(C_DONE, 0); push_code(C_IDLE, 0);
    push_bits(16'h00DD, 8, 1); push_code(C_DONE, 1); push_code(C_IDLE, 1);
    launch(8'h0D, 4'd4, 4'd1);
    run_check("0d_rep1");

    // maximum repeat count: 16 frames of "10"
    for (int f = 0; f < 16; f++) begin
      push_bits(16'h0002, 2, 2);
      if (f < 15) push_code(C_GAP, 0);
    end
    push_code(C_DONE, 2); push_code(C_IDLE, 2);
    launch(8'h02, 4'd2, 4'd15);
    run_check("rep15");

    // start wins over abort in idle; abort during cycle 3 kills the frame
    abort = 1'b1;
    launch(8'hB2, 4'd8, 4'd0);
    abort = 1'b0;
    chk_both("abort c1", 4'b1100);
    step();
    chk_both("abort c2", 4'b1000);
    step();
    chk_both("abort c3", 4'b1100);
    abort = 1'b1;
    step();
    chk_both("abort c4", C_IDLE);
    abort = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_both($sformatf("abort_nodone c%0d", i + 5), C_IDLE);
    end

    // start held high and inputs changed mid-transfer: original pattern finishes, no restart
    data = 8'hB2; len = 4'd8; rep = 4'd0; start = 1'b1;
    step();
    data = 8'hFF; len = 4'd3; rep = 4'd5;
    push_bits(16'h00B2, 8, 2); push_code(C_DONE, 2);
    run_check("hold_start");
    chk_both("hold_start c10", C_IDLE);
    start = 1'b0;
    step();
    chk_both("hold_start c11", C_IDLE);

    // clear in cycle 5 truncates; start accepted at the first edge after clear drops
    push_bits(16'h000B, 4, 2);
    launch(8'hB2, 4'd8, 4'd0);
    run_check("clr_mid");
    chk_both("clr_mid c5", 4'b1000);
    clr = 1'b1;
    step();
    chk_both("clr_mid c6", C_IDLE);
    clr = 1'b0;
    push_bits(16'h0005, 3, 2); push_code(C_DONE, 2); push_code(C_IDLE, 2);
    launch(8'h05, 4'd3, 4'd0);
    run_check("after_clr");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
